// File: rtl/cim_csr_bank_if.sv
// Register-bus link between the AHB-to-CSR bridge (master) and the CIM CSR bank (slave).
interface cim_csr_bank_if;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic [31:0] reg_rdata;

  modport master (output reg_addr, output reg_wdata, output reg_we, input reg_rdata);
  modport slave  (input reg_addr, input reg_wdata, input reg_we, output reg_rdata);
endinterface

// File: rtl/cim_csr_bank.sv
// CSR bank for the CIM compute engine: job parameters, start/track FSM, cycle counter,
// W1C status bits and a level interrupt.
module cim_csr_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h4350_0001,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  cim_csr_bank_if.slave    bus,
  output logic             eng_start,
  output logic [3:0]       eng_mode,
  output logic [31:0]      eng_src,
  output logic [31:0]      eng_dst,
  output logic [LEN_W-1:0] eng_len,
  input  logic             eng_done,
  input  logic             eng_err,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

  state_t           state_q;
  logic             start_q;
  logic             irq_en_q, irq_en_d;
  logic [3:0]       mode_q, mode_d;
  logic             done_q, done_d, err_q, err_d, rej_q, rej_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d, scratch_q, scratch_d, cyc_q, cyc_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic        in_region, wr, busy, start_req, start_ok, start_bad, start_busy;
  logic        in_run, ev, done_set, err_set, rej_set;
  logic [2:0]  off;
  logic [31:0] wdata, rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus.reg_addr[1:0];
  assign in_region  = (bus.reg_addr[31:5] == BASE_ADDR[31:5]);
  assign off        = bus.reg_addr[4:2];
  assign wdata      = bus.reg_wdata;
  assign wr         = bus.reg_we & in_region;
  assign busy       = (state_q != IDLE);
  assign in_run     = (state_q == RUN);
  assign ev         = eng_done | eng_err;
  assign start_req  = wr && (off == 3'd0) && wdata[0];
  assign start_ok   = start_req && !busy && (len_q != '0);
  assign start_bad  = start_req && !busy && (len_q == '0);
  assign start_busy = start_req && busy;
  // Engine events outside RUN are spurious and only flag ERR.
  assign done_set   = in_run & eng_done;
  assign err_set    = (in_run & eng_err) | (!in_run & ev) | start_bad;
  assign rej_set    = start_bad | start_busy;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= LAUNCH;
            start_q <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q <= RUN;
          start_q <= 1'b0;
        end
        RUN: begin
          if (ev) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  // Hardware sets are applied after software W1C clears so a colliding set wins.
  always_comb begin
    irq_en_d  = irq_en_q;
    mode_d    = mode_q;
    done_d    = done_q;
    err_d     = err_q;
    rej_d     = rej_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    scratch_d = scratch_q;
    cyc_d     = cyc_q;
    if (wr) begin
      case (off)
        3'd0: begin
          irq_en_d = wdata[1];
          mode_d   = wdata[7:4];
        end
        3'd1: begin
          if (wdata[1]) done_d = 1'b0;
          if (wdata[2]) err_d  = 1'b0;
          if (wdata[3]) rej_d  = 1'b0;
        end
        3'd2:    src_d     = wdata;
        3'd3:    dst_d     = wdata;
        3'd4:    len_d     = wdata[LEN_W-1:0];
        3'd6:    scratch_d = wdata;
        default: ;
      endcase
    end
    if (start_ok) begin
      cyc_d  = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
    end else if (busy && (cyc_q != '1)) begin
      cyc_d = cyc_q + 32'd1;
    end
    if (done_set) done_d = 1'b1;
    if (err_set)  err_d  = 1'b1;
    if (rej_set)  rej_d  = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_en_q  <= 1'b0;
      mode_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rej_q     <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      scratch_q <= '0;
      cyc_q     <= '0;
    end else begin
      irq_en_q  <= irq_en_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rej_q     <= rej_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      scratch_q <= scratch_d;
      cyc_q     <= cyc_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (in_region) begin
      case (off)
        3'd0:    rdata = {24'd0, mode_q, 2'b00, irq_en_q, 1'b0};
        3'd1:    rdata = {28'd0, rej_q, err_q, done_q, busy};
        3'd2:    rdata = src_q;
        3'd3:    rdata = dst_q;
        3'd4:    rdata[LEN_W-1:0] = len_q;
        3'd5:    rdata = cyc_q;
        3'd6:    rdata = scratch_q;
        default: rdata = ID_VALUE;
      endcase
    end
  end

  assign bus.reg_rdata = rdata;
  assign eng_start     = start_q;
  assign eng_mode      = mode_q;
  assign eng_src       = src_q;
  assign eng_dst       = dst_q;
  assign eng_len       = len_q;
  assign irq           = irq_en_q & (done_q | err_q);

endmodule

// File: tb/tb_cim_csr_bank.sv
// Directed self-checking bench for cim_csr_bank: register access, job flow, rejections,
// W1C collisions, spurious events and asynchronous reset.
module tb_cim_csr_bank;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] ID_VAL = 32'h4350_0001;
  localparam logic [31:0] CTRL   = BASE + 32'h00;
  localparam logic [31:0] STATUS = BASE + 32'h04;
  localparam logic [31:0] SRC    = BASE + 32'h08;
  localparam logic [31:0] LEN    = BASE + 32'h10;
  localparam logic [31:0] CYC    = BASE + 32'h14;
  localparam logic [31:0] SCR    = BASE + 32'h18;
  localparam logic [31:0] IDREG  = BASE + 32'h1C;

  logic        HCLK;
  logic        HRESETn;
  logic        eng_start;
  logic [3:0]  eng_mode;
  logic [31:0] eng_src;
  logic [31:0] eng_dst;
  logic [15:0] eng_len;
  logic        eng_done;
  logic        eng_err;
  logic        irq;
  int          checks;
  int          errors;
  int          startCount;

  cim_csr_bank_if bus ();

  cim_csr_bank #(
    .BASE_ADDR (BASE),
    .ID_VALUE  (ID_VAL),
    .LEN_W     (16)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .eng_start (eng_start),
    .eng_mode  (eng_mode),
    .eng_src   (eng_src),
    .eng_dst   (eng_dst),
    .eng_len   (eng_len),
    .eng_done  (eng_done),
    .eng_err   (eng_err),
    .irq       (irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // One write beat; returns 1 ns after the sampling edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    bus.reg_addr  = addr;
    bus.reg_wdata = data;
    bus.reg_we    = 1'b1;
    @(posedge HCLK);
    #1;
    bus.reg_we    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkReg(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    bus.reg_addr = addr;
    bus.reg_we   = 1'b0;
    #1;
    checkOutput(tag, bus.reg_rdata, expected);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    HRESETn       = 1'b0;
    eng_done      = 1'b0;
    eng_err       = 1'b0;
    bus.reg_addr  = IDREG;
    bus.reg_wdata = '0;
    bus.reg_we    = 1'b0;

    #1;
    checkOutput("rst_eng_start", {31'd0, eng_start}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_eng_mode", {28'd0, eng_mode}, 32'd0);
    checkOutput("rst_eng_src", eng_src, 32'd0);
    checkOutput("rst_eng_dst", eng_dst, 32'd0);
    checkOutput("rst_eng_len", {16'd0, eng_len}, 32'd0);
    checkReg("rst_id", IDREG, ID_VAL);
    #21;
    HRESETn = 1'b1;
    tick();
    $display("[TB] reset released");
    checkReg("id", IDREG, ID_VAL);
    for (int i = 0; i < 7; i++) begin
      checkReg($sformatf("rst_reg_%0d", i * 4), BASE + 32'(i * 4), 32'd0);
    end
    tick();

    applyStimulus(SRC, 32'hDEAD_BEEF);
    applyStimulus(LEN, 32'h0001_0040);
    applyStimulus(SCR, 32'h5A5A_5A5A);
    checkReg("src_rb", SRC, 32'hDEAD_BEEF);
    checkReg("len_rb", LEN, 32'h0000_0040);
    checkReg("scr_rb", SCR, 32'h5A5A_5A5A);
    checkOutput("eng_src", eng_src, 32'hDEAD_BEEF);
    checkOutput("eng_len", {16'd0, eng_len}, 32'h0000_0040);
    applyStimulus(CYC, 32'hFFFF_FFFF);
    applyStimulus(IDREG, 32'h1234_5678);
    applyStimulus(32'h5000_0018, 32'h1111_1111);
    checkReg("cyc_ro", CYC, 32'd0);
    checkReg("id_ro", IDREG, ID_VAL);
    checkReg("scr_outside_wr", SCR, 32'h5A5A_5A5A);
    checkReg("outside_rd", BASE + 32'h40, 32'd0);
    tick();

    $display("[TB] full job");
    applyStimulus(LEN, 32'd8);
    applyStimulus(CTRL, 32'h0000_0013);
    checkOutput("job_start_hi", {31'd0, eng_start}, 32'd1);
    checkOutput("job_mode", {28'd0, eng_mode}, 32'd1);
    checkReg("job_busy_launch", STATUS, 32'h1);
    checkReg("job_ctrl_rb", CTRL, 32'h12);
    tick();
    checkOutput("job_start_lo", {31'd0, eng_start}, 32'd0);
    checkReg("job_cyc1", CYC, 32'd1);
    startCount = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (eng_start) startCount++;
    end
    checkOutput("job_extra_start", 32'(startCount), 32'd0);
    eng_done = 1'b1;
    checkReg("job_busy_run", STATUS, 32'h1);
    tick();
    eng_done = 1'b0;
    checkReg("job_status_done", STATUS, 32'h2);
    checkReg("job_cyc11", CYC, 32'd11);
    checkOutput("job_irq", {31'd0, irq}, 32'd1);
    applyStimulus(STATUS, 32'h2);
    checkOutput("job_irq_clr", {31'd0, irq}, 32'd0);
    checkReg("job_status_clr", STATUS, 32'h0);

    $display("[TB] rejections");
    applyStimulus(LEN, 32'd0);
    applyStimulus(CTRL, 32'h3);
    checkOutput("rej_len0_start", {31'd0, eng_start}, 32'd0);
    checkReg("rej_len0_status", STATUS, 32'hC);
    checkOutput("rej_len0_irq", {31'd0, irq}, 32'd1);
    applyStimulus(STATUS, 32'hE);
    checkReg("rej_len0_clr", STATUS, 32'h0);
    applyStimulus(LEN, 32'd4);
    applyStimulus(CTRL, 32'h3);
    checkOutput("rej_run_start1", {31'd0, eng_start}, 32'd1);
    tick();
    applyStimulus(CTRL, 32'h53);
    checkOutput("rej_run_nostart", {31'd0, eng_start}, 32'd0);
    checkReg("rej_run_status", STATUS, 32'h9);
    checkOutput("rej_run_mode", {28'd0, eng_mode}, 32'd5);
    tick();
    checkOutput("rej_run_nostart2", {31'd0, eng_start}, 32'd0);
    checkReg("rej_run_still", STATUS, 32'h9);

    $display("[TB] collision and spurious events");
    eng_done = 1'b1;
    applyStimulus(STATUS, 32'h2);
    eng_done = 1'b0;
    checkReg("coll_done_wins", STATUS, 32'hA);
    applyStimulus(STATUS, 32'h8);
    checkReg("coll_rej_clr", STATUS, 32'h2);
    eng_err = 1'b1;
    tick();
    eng_err = 1'b0;
    checkReg("spur_err_idle", STATUS, 32'h6);
    applyStimulus(STATUS, 32'h6);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    checkReg("spur_done_idle", STATUS, 32'h4);
    applyStimulus(STATUS, 32'h4);
    checkReg("spur_clr", STATUS, 32'h0);

    $display("[TB] reset mid-job");
    applyStimulus(CTRL, 32'h3);
    eng_err = 1'b1;
    tick();
    eng_err = 1'b0;
    checkOutput("mid_irq_hi", {31'd0, irq}, 32'd1);
    checkReg("mid_status", STATUS, 32'h5);
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("mid_irq_async", {31'd0, irq}, 32'd0);
    checkOutput("mid_start_async", {31'd0, eng_start}, 32'd0);
    checkReg("mid_busy_async", STATUS, 32'h0);
    checkOutput("mid_len_async", {16'd0, eng_len}, 32'd0);
    #3;
    HRESETn = 1'b1;
    tick();
    applyStimulus(LEN, 32'd4);
    applyStimulus(CTRL, 32'h1);
    checkOutput("post_rst_start", {31'd0, eng_start}, 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("launch_start_async", {31'd0, eng_start}, 32'd0);
    checkReg("launch_busy_async", STATUS, 32'h0);
    #3;
    HRESETn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cim_csr_bank.md
# cim_csr_bank

CSR register bank for the CIM compute engine. It sits directly downstream of the AHB-to-CSR bridge and consumes that bridge's `reg_addr`, write data and `reg_we`. It returns read data combinationally from the registered address. Toward the engine it drives job parameters and a one-cycle start pulse, tracks the job with a small FSM, counts job cycles, and raises a level interrupt.

## Interface
Parameters:
- BASE_ADDR, 32'h4000_0000, region base; block decodes 32 bytes; `reg_addr[31:5]` must equal `BASE_ADDR[31:5]`.
- ID_VALUE, 32'h4350_0001, constant returned by ID register.
- LEN_W, 16, width of LEN field (1..32).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- reg_addr  in  32  byte address from bridge; word-aligned, bits [1:0] ignored.
- reg_wdata  in  32  write data from bridge.
- reg_we  in  1  write strobe, one cycle per write beat.
- reg_rdata  out  32  read data, combinational from `reg_addr`.
- eng_start  out  1  one-cycle job start pulse.
- eng_mode  out  4  CTRL.MODE.
- eng_src  out  32  SRC_ADDR.
- eng_dst  out  32  DST_ADDR.
- eng_len  out  LEN_W  LEN.
- eng_done  in  1  one-cycle job-complete pulse from engine.
- eng_err  in  1  one-cycle job-error pulse from engine.
- irq  out  1  level interrupt.

## Operation
Register map (offsets from BASE_ADDR):
- 0x00 CTRL, RW except bit0.
  - bit0 START: write-1 requests start; reads 0.
  - bit1 IRQ_EN.
  - [7:4] MODE.
  - Other bits read 0.
- 0x04 STATUS.
  - bit0 BUSY: RO; 1 when FSM is not IDLE.
  - bit1 DONE: W1C.
  - bit2 ERR: W1C.
  - bit3 REJ: W1C; a start was rejected.
- 0x08 SRC_ADDR, RW, 32 bits.
- 0x0C DST_ADDR, RW, 32 bits.
- 0x10 LEN, RW, [LEN_W-1:0]; upper bits read 0.
- 0x14 CYC_CNT, RO; cycles spent in LAUNCH+RUN for the last/current job.
- 0x18 SCRATCH, RW, 32 bits.
- 0x1C ID, RO, ID_VALUE.

Address decoding:
- Address outside the region: write ignored, `reg_rdata`=0.
- Writes to RO registers/bits ignored.

Job FSM (IDLE, LAUNCH, RUN):
- IDLE→LAUNCH: CTRL write with bit0=1 and LEN≠0.
  - On this transition, CYC_CNT is cleared to 0 and DONE and ERR are cleared.
- CTRL write with bit0=1 and LEN==0: no transition; sets ERR and REJ.
- CTRL write with bit0=1 in LAUNCH or RUN: ignored for the FSM; sets REJ; other CTRL fields are still written.
- LAUNCH→RUN: unconditional after one cycle; `eng_start`=1 only in LAUNCH.
- RUN→IDLE on `eng_done` (sets DONE) or `eng_err` (sets ERR). If both are asserted, both bits are set.
- `eng_done`/`eng_err` in IDLE or LAUNCH: DONE unaffected; sets ERR (spurious).
- CYC_CNT increments each cycle in LAUNCH or RUN, saturating at 32'hFFFF_FFFF. It holds its value in IDLE.
- W1C collision: a hardware set in the same cycle as a software W1C clear of the same bit leaves the bit set.
- `irq` = IRQ_EN & (DONE | ERR); REJ does not interrupt.
- SRC, DST, LEN and MODE stay writable while busy. The engine samples them at `eng_start`; later writes do not affect the running job.

## Timing
- Reset values:
  - All registers 0; FSM IDLE.
  - `eng_start`=0, `irq`=0, `eng_*` outputs 0.
  - `reg_rdata` = decode of `reg_addr` with reset register values (ID still reads ID_VALUE).
- Writes are sampled on the HCLK edge where `reg_we`=1. The new value is visible on `reg_rdata` and outputs the next cycle.
- Start latency: `eng_start` is high in cycle N+1 after a START write at edge N. CYC_CNT reads 1 at cycle N+2.
- DONE/ERR are set and FSM=IDLE the cycle after `eng_done`/`eng_err`; `irq` rises in that same cycle.
- A new START is accepted at the first edge where FSM=IDLE, i.e. one cycle after `eng_done`.
- Asynchronous reset mid-job: FSM to IDLE immediately; `eng_start` and `irq` drop without waiting for a clock.

## Test plan
- Reset and ID:
  - Stimulus: assert HRESETn low, then release.
  - Required: all outputs 0; read 0x1C=32'h4350_0001; read 0x00..0x18 = 0.
- RW registers:
  - Stimulus: write 0x08=32'hDEAD_BEEF, 0x10=32'h0001_0040, 0x18=32'h5A5A_5A5A.
  - Required: readback DEAD_BEEF, 0000_0040, 5A5A_5A5A.
  - Stimulus: write 0x14 and 0x1C.
  - Required: values unchanged.
  - Stimulus: read address BASE+0x40.
  - Required: 0.
- Full job:
  - Stimulus: LEN=8, write CTRL=32'h0000_0013; pulse `eng_done` 10 cycles after `eng_start`.
  - Required: `eng_start` for exactly one cycle; BUSY=1 during the job; CYC_CNT=11; STATUS=0x2; `irq`=1.
  - Stimulus: write STATUS=0x2.
  - Required: `irq`=0.
- Rejections:
  - Stimulus: START with LEN=0.
  - Required: STATUS=0xC, no `eng_start`.
  - Stimulus: START while in RUN.
  - Required: REJ=1, FSM stays RUN, no second `eng_start`.
- Collision and spurious events:
  - Stimulus: `eng_done` in the same cycle as a write of STATUS=0x2.
  - Required: DONE=1.
  - Stimulus: `eng_err` in IDLE.
  - Required: ERR=1, DONE unchanged.
- Reset mid-job:
  - Stimulus: drop HRESETn during RUN.
  - Required: `irq`, `eng_start` and BUSY go 0 asynchronously; after release a new START is accepted.
